mem_traffic_counter_bank: RTL and testbench

Parametrised per-channel memory-traffic counter bank that sits beside the CXL IP memory-channel interface in the AFU. It counts reads, writes and partial (read-modify-write) writes per channel and records the last read address per channel. It takes an atomic snapshot of all counters, either periodically or on host command, and streams the snapshot into the custom CSR regfile through the update port, one entry per cycle.

---
 rtl/mem_traffic_counter_bank.sv | 167 ++++++++++++++++
 tb/tb_mem_traffic_counter_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_traffic_counter_bank.sv
// Per-channel read/write/partial-write counters plus last read address, snapshotted atomically and streamed to the CSR regfile.
// Latency: events reach the live counters one cycle later; the stream occupies the N_ENTRIES cycles after the capture edge.
// Backpressure: none; the regfile takes one update per cycle, and snapshot requests during a stream fold into one pending request.
module mem_traffic_counter_bank #(
  parameter int MC_CHANNEL        = 2,
  parameter int CNT_WIDTH         = 64,
  parameter int BE_WIDTH          = 64,
  parameter int ADDR_WIDTH        = 52,
  parameter int SATURATE          = 0,
  parameter int N_ENTRIES         = 4*MC_CHANNEL+2,
  parameter int CSR_ADDRESS_WIDTH = $clog2(N_ENTRIES)+1
) (
  input  logic                                  afu_clk,
  input  logic                                  afu_rst,
  input  logic [MC_CHANNEL-1:0]                 cxlip2iafu_read_eclk,
  input  logic [MC_CHANNEL-1:0]                 cxlip2iafu_write_eclk,
  input  logic [MC_CHANNEL-1:0][BE_WIDTH-1:0]   cxlip2iafu_byteenable_eclk,
  input  logic [MC_CHANNEL-1:0][ADDR_WIDTH-1:0] cxlip2iafu_address_eclk,
  input  logic                                  ctrl_enable,
  input  logic                                  ctrl_clear,
  input  logic                                  ctrl_snapshot,
  input  logic [31:0]                           ctrl_interval,
  output logic                                  csr_update,
  output logic [CSR_ADDRESS_WIDTH-1:0]          csr_update_addr,
  output logic [63:0]                           csr_update_data,
  output logic                                  busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [CSR_ADDRESS_WIDTH-1:0] LAST_IDX = CSR_ADDRESS_WIDTH'(N_ENTRIES-1);

  logic [CNT_WIDTH-1:0]         rd_cnt [MC_CHANNEL];
  logic [CNT_WIDTH-1:0]         wr_cnt [MC_CHANNEL];
  logic [CNT_WIDTH-1:0]         pw_cnt [MC_CHANNEL];
  logic [ADDR_WIDTH-1:0]        la_reg [MC_CHANNEL];
  logic [63:0]                  shadow [N_ENTRIES];
  logic [31:0]                  seq;
  logic [31:0]                  tmr;
  logic                         pending;
  logic                         trigger;
  logic                         capture;
  state_t                       state, state_nxt;
  logic [CSR_ADDRESS_WIDTH-1:0] idx, idx_nxt;

  // Counter step: sticks at all-ones when saturating, otherwise wraps.
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (SATURATE != 0 && (&v)) r = v;
    else                       r = v + CNT_WIDTH'(1);
    return r;
  endfunction

  // Live counters: clear beats any same-cycle event; counting only while enabled.
  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      for (int c = 0; c < MC_CHANNEL; c++) begin
        rd_cnt[c] <= '0;
        wr_cnt[c] <= '0;
        pw_cnt[c] <= '0;
        la_reg[c] <= '0;
      end
    end else if (ctrl_clear) begin
      for (int c = 0; c < MC_CHANNEL; c++) begin
        rd_cnt[c] <= '0;
        wr_cnt[c] <= '0;
        pw_cnt[c] <= '0;
        la_reg[c] <= '0;
      end
    end else if (ctrl_enable) begin
      for (int c = 0; c < MC_CHANNEL; c++) begin
        if (cxlip2iafu_read_eclk[c]) begin
          rd_cnt[c] <= bump(rd_cnt[c]);
          la_reg[c] <= cxlip2iafu_address_eclk[c];
        end
        if (cxlip2iafu_write_eclk[c]) begin
          wr_cnt[c] <= bump(wr_cnt[c]);
          if (cxlip2iafu_byteenable_eclk[c] != '1) pw_cnt[c] <= bump(pw_cnt[c]);
        end
      end
    end
  end

  // Snapshot trigger as seen while idle; the interval guard keeps interval-1 from underflowing.
  always_comb begin
    trigger = ctrl_snapshot || pending ||
              (ctrl_enable && (ctrl_interval != 32'd0) && (tmr >= ctrl_interval - 32'd1));
  end

  // State and stream index registers.
  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic and update strobe/address; outputs follow the state register directly.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    capture         = 1'b0;
    csr_update      = 1'b0;
    csr_update_addr = '0;
    busy            = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          capture   = 1'b1;
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        csr_update      = 1'b1;
        busy            = 1'b1;
        csr_update_addr = idx;
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + CSR_ADDRESS_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Update data: shadow entry selected by the stream index.
  always_comb begin
    csr_update_data = '0;
    if (state == STREAM) begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        if (idx == CSR_ADDRESS_WIDTH'(e)) csr_update_data = shadow[e];
      end
    end
  end

  // Shadow capture, sequence number, interval timer and the one-deep pending request.
  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      seq     <= '0;
      tmr     <= '0;
      pending <= 1'b0;
      for (int e = 0; e < N_ENTRIES; e++) shadow[e] <= '0;
    end else if (capture) begin
      for (int c = 0; c < MC_CHANNEL; c++) begin
        shadow[4*c+0] <= 64'(rd_cnt[c]);
        shadow[4*c+1] <= 64'(wr_cnt[c]);
        shadow[4*c+2] <= 64'(pw_cnt[c]);
        shadow[4*c+3] <= 64'(la_reg[c]);
      end
      shadow[4*MC_CHANNEL]   <= 64'(seq + 32'd1);
      shadow[4*MC_CHANNEL+1] <= 64'(tmr);
      seq     <= seq + 32'd1;
      tmr     <= '0;
      pending <= 1'b0;
    end else begin
      if (state == IDLE && ctrl_enable)    tmr     <= tmr + 32'd1;
      if (state == STREAM && ctrl_snapshot) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_traffic_counter_bank.sv
// Directed bench for mem_traffic_counter_bank: default build plus 4-bit saturating and wrapping builds on shared stimulus.
// Latency: checks the capture edge, N_ENTRIES-cycle stream and one-idle-cycle gap between back-to-back streams.
// Backpressure: none in the design; every wait on a stream is bounded by a cycle budget.
module tb_mem_traffic_counter_bank;
  localparam int NE = 10;

  logic             afu_clk = 1'b0;
  logic             afu_rst = 1'b1;
  logic [1:0]       rd, wr;
  logic [1:0][63:0] be;
  logic [1:0][51:0] addr;
  logic             en, clr, snap;
  logic [31:0]      intv;

  logic        upd_m, upd_s, upd_w, busy_m, busy_s, busy_w;
  logic [4:0]  addr_m, addr_s, addr_w;
  logic [63:0] dat_m, dat_s, dat_w;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [63:0] got_m [NE];
  logic [63:0] got_s [NE];
  logic [63:0] got_w [NE];
  logic [4:0]  got_a [NE];
  int          got_upd, got_busy, got_start;
  logic        got_tail;

  mem_traffic_counter_bank dut_m (
    .afu_clk(afu_clk), .afu_rst(afu_rst),
    .cxlip2iafu_read_eclk(rd), .cxlip2iafu_write_eclk(wr),
    .cxlip2iafu_byteenable_eclk(be), .cxlip2iafu_address_eclk(addr),
    .ctrl_enable(en), .ctrl_clear(clr), .ctrl_snapshot(snap), .ctrl_interval(intv),
    .csr_update(upd_m), .csr_update_addr(addr_m), .csr_update_data(dat_m), .busy(busy_m)
  );

  mem_traffic_counter_bank #(.CNT_WIDTH(4), .SATURATE(1)) dut_s (
    .afu_clk(afu_clk), .afu_rst(afu_rst),
    .cxlip2iafu_read_eclk(rd), .cxlip2iafu_write_eclk(wr),
    .cxlip2iafu_byteenable_eclk(be), .cxlip2iafu_address_eclk(addr),
    .ctrl_enable(en), .ctrl_clear(clr), .ctrl_snapshot(snap), .ctrl_interval(intv),
    .csr_update(upd_s), .csr_update_addr(addr_s), .csr_update_data(dat_s), .busy(busy_s)
  );

  mem_traffic_counter_bank #(.CNT_WIDTH(4), .SATURATE(0)) dut_w (
    .afu_clk(afu_clk), .afu_rst(afu_rst),
    .cxlip2iafu_read_eclk(rd), .cxlip2iafu_write_eclk(wr),
    .cxlip2iafu_byteenable_eclk(be), .cxlip2iafu_address_eclk(addr),
    .ctrl_enable(en), .ctrl_clear(clr), .ctrl_snapshot(snap), .ctrl_interval(intv),
    .csr_update(upd_w), .csr_update_addr(addr_w), .csr_update_data(dat_w), .busy(busy_w)
  );

  always #5 afu_clk = ~afu_clk;

  always @(posedge afu_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge afu_clk);
    #1;
  endtask

  task automatic pulse_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  // Waits (bounded) for a stream to start, then records its N entries and the cycle after.
  task automatic collect(input int budget);
    int n;
    n = 0;
    while (!upd_m && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!upd_m) begin
      errors++;
      $display("FAIL stream_timeout: csr_update=%0b after %0d cycles, required 1", upd_m, budget);
    end
    got_start = cyc;
    got_upd   = 0;
    got_busy  = 0;
    for (int i = 0; i < NE; i++) begin
      got_m[i] = dat_m;
      got_s[i] = dat_s;
      got_w[i] = dat_w;
      got_a[i] = addr_m;
      if (upd_m)  got_upd++;
      if (busy_m) got_busy++;
      tick();
    end
    got_tail = upd_m;
  endtask

  task automatic test_reset();
    logic [63:0] want;
    afu_rst = 1'b1;
    rd = '0; wr = '0; be = '1; addr = '0;
    en = 1'b0; clr = 1'b0; snap = 1'b0; intv = '0;
    repeat (3) tick();
    checks++;
    if (upd_m !== 1'b0) begin errors++; $display("FAIL reset_update: got %0b want 0", upd_m); end
    checks++;
    if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_m); end
    checks++;
    if (addr_m !== 5'd0 || dat_m !== 64'd0) begin
      errors++; $display("FAIL reset_addr_data: got %0h/%0h want 0/0", addr_m, dat_m);
    end
    afu_rst = 1'b0;
    repeat (4) tick();
    pulse_snap();
    collect(5);
    checks++;
    if (got_upd !== NE) begin errors++; $display("FAIL first_stream_len: got %0d want %0d", got_upd, NE); end
    checks++;
    if (got_busy !== NE) begin errors++; $display("FAIL first_stream_busy: got %0d want %0d", got_busy, NE); end
    checks++;
    if (got_tail !== 1'b0) begin errors++; $display("FAIL first_stream_tail: got %0b want 0", got_tail); end
    for (int i = 0; i < NE; i++) begin
      want = (i == 8) ? 64'd1 : 64'd0;
      checks++;
      if (got_a[i] !== 5'(i)) begin errors++; $display("FAIL first_addr[%0d]: got %0d want %0d", i, got_a[i], i); end
      checks++;
      if (got_m[i] !== want) begin errors++; $display("FAIL first_data[%0d]: got %0h want %0h", i, got_m[i], want); end
    end
  endtask

  task automatic test_counting();
    logic [63:0] want [NE];
    want = '{64'd3, 64'd4, 64'd1, 64'h300, 64'd2, 64'd0, 64'd0, 64'h1234, 64'd2, 64'd4};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd[0]   = (i < 3);
      addr[0] = 52'(64'h100 * (i + 1));
      rd[1]   = (i < 2);
      addr[1] = (i == 0) ? 52'h5555 : 52'h1234;
      wr[0]   = 1'b1;
      be[0]   = (i == 2) ? 64'hFFFF_FFFF_FFFF_FF7F : '1;
      tick();
    end
    rd = '0; wr = '0; be = '1;
    pulse_snap();
    collect(5);
    for (int i = 0; i < NE; i++) begin
      checks++;
      if (got_m[i] !== want[i]) begin errors++; $display("FAIL count_data[%0d]: got %0h want %0h", i, got_m[i], want[i]); end
    end
  endtask

  task automatic test_clear();
    logic [63:0] want [NE];
    want = '{64'd0, 64'd9, 64'd0, 64'd0, 64'd0, 64'd9, 64'd0, 64'd0, 64'd3, 64'd20};
    for (int i = 0; i < 20; i++) begin
      wr  = 2'b11;
      clr = (i == 10);
      tick();
    end
    wr = '0; clr = 1'b0;
    pulse_snap();
    collect(5);
    for (int i = 0; i < NE; i++) begin
      checks++;
      if (got_m[i] !== want[i]) begin errors++; $display("FAIL clear_data[%0d]: got %0h want %0h", i, got_m[i], want[i]); end
    end
  endtask

  task automatic test_periodic();
    int start_a;
    int seen;
    intv = 32'd100;
    collect(200);
    start_a = got_start;
    checks++;
    if (got_m[8] !== 64'd4) begin errors++; $display("FAIL periodic_seq_a: got %0d want 4", got_m[8]); end
    checks++;
    if (got_m[9] !== 64'd99) begin errors++; $display("FAIL periodic_elapsed_a: got %0d want 99", got_m[9]); end
    collect(200);
    checks++;
    if (got_start - start_a !== 110) begin errors++; $display("FAIL periodic_spacing: got %0d want 110", got_start - start_a); end
    checks++;
    if (got_m[8] !== 64'd5) begin errors++; $display("FAIL periodic_seq_b: got %0d want 5", got_m[8]); end
    checks++;
    if (got_m[9] !== 64'd99) begin errors++; $display("FAIL periodic_elapsed_b: got %0d want 99", got_m[9]); end
    intv = 32'd0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (upd_m) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL periodic_off: got %0d update cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic        u [25];
    logic [4:0]  a [25];
    logic [63:0] d [25];
    int          cnt;
    pulse_snap();
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      u[k] = upd_m;
      a[k] = addr_m;
      d[k] = dat_m;
      if (upd_m) cnt++;
      snap = (k == 2 || k == 5);
      tick();
    end
    snap = 1'b0;
    checks++;
    if (cnt !== 20) begin errors++; $display("FAIL b2b_total: got %0d update cycles want 20", cnt); end
    checks++;
    if (u[10] !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %0b want 0", u[10]); end
    checks++;
    if (u[11] !== 1'b1 || a[11] !== 5'd0) begin errors++; $display("FAIL b2b_second_start: got %0b/%0d want 1/0", u[11], a[11]); end
    checks++;
    if (a[20] !== 5'd9) begin errors++; $display("FAIL b2b_second_last: got %0d want 9", a[20]); end
    checks++;
    if (u[21] !== 1'b0) begin errors++; $display("FAIL b2b_no_third: got %0b want 0", u[21]); end
    checks++;
    if (d[8] !== 64'd6 || d[19] !== 64'd7) begin errors++; $display("FAIL b2b_seq: got %0d/%0d want 6/7", d[8], d[19]); end
  endtask

  task automatic test_saturate();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    rd = 2'b01;
    addr[0] = 52'hABC;
    repeat (20) tick();
    rd = '0;
    pulse_snap();
    collect(5);
    checks++;
    if (got_s[0] !== 64'd15) begin errors++; $display("FAIL sat_rd0: got %0d want 15", got_s[0]); end
    checks++;
    if (got_w[0] !== 64'd4) begin errors++; $display("FAIL wrap_rd0: got %0d want 4", got_w[0]); end
    checks++;
    if (got_m[0] !== 64'd20) begin errors++; $display("FAIL wide_rd0: got %0d want 20", got_m[0]); end
    checks++;
    if (got_s[3] !== 64'hABC) begin errors++; $display("FAIL sat_la0: got %0h want abc", got_s[3]); end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] want;
    pulse_snap();
    tick();
    tick();
    #2 afu_rst = 1'b1;
    #1;
    checks++;
    if (upd_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++; $display("FAIL rst_abort: got update=%0b busy=%0b want 0/0", upd_m, busy_m);
    end
    checks++;
    if (upd_s !== 1'b0) begin errors++; $display("FAIL rst_abort_sat: got %0b want 0", upd_s); end
    tick();
    afu_rst = 1'b0;
    en = 1'b0;
    tick();
    pulse_snap();
    collect(5);
    for (int i = 0; i < NE; i++) begin
      want = (i == 8) ? 64'd1 : 64'd0;
      checks++;
      if (got_m[i] !== want) begin errors++; $display("FAIL rst_data[%0d]: got %0h want %0h", i, got_m[i], want); end
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_clear();
    test_periodic();
    test_back_to_back();
    test_saturate();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
